// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  // Index width never collapses to zero, even for a single source.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // last_grant resets to the highest index so source 0 wins the first pick.
  function automatic int unsigned last_grant_rst(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin pick: first request above last_i, wrapping around.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int unsigned C_NUM_SOURCES = 4,
  parameter int unsigned IW            = idx_width(C_NUM_SOURCES)
) (
  input  logic [C_NUM_SOURCES-1:0] req_i,
  input  logic [IW-1:0]            last_i,
  output logic                     valid_o,
  output logic [IW-1:0]            idx_o
);

  int unsigned    cand;
  logic [IW-1:0]  cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= C_NUM_SOURCES; k++) begin
      cand     = (32'(last_i) + k) % C_NUM_SOURCES;
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 AXI4-Stream arbiter: packet-held round-robin grant, registered output
// slice, and a beat-count watchdog that force-terminates runaway packets.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_NUM_SOURCES      = 4,
  parameter int unsigned C_MAX_PKT_WORDS    = 8
) (
  input  logic                                            M_AXIS_ACLK,
  input  logic                                            M_AXIS_ARESETN,
  input  logic [C_NUM_SOURCES-1:0]                        S_AXIS_TVALID,
  input  logic [C_NUM_SOURCES*C_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_NUM_SOURCES*C_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TSTRB,
  input  logic [C_NUM_SOURCES-1:0]                        S_AXIS_TLAST,
  output logic [C_NUM_SOURCES-1:0]                        S_AXIS_TREADY,
  output logic                                            M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]                 M_AXIS_TSTRB,
  output logic                                            M_AXIS_TLAST,
  input  logic                                            M_AXIS_TREADY,
  output logic [idx_width(C_NUM_SOURCES)-1:0]             GRANT_ID,
  output logic                                            PKT_OVERRUN
);

  localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned IW = idx_width(C_NUM_SOURCES);
  localparam int unsigned CW = $clog2(C_MAX_PKT_WORDS + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(last_grant_rst(C_NUM_SOURCES));

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           m_valid_q, m_valid_d;
  logic [DW-1:0]  m_data_q, m_data_d;
  logic [SW-1:0]  m_strb_q, m_strb_d;
  logic           m_last_q, m_last_d;
  logic           ovr_q, ovr_d;

  logic           pick_valid;
  logic [IW-1:0]  pick_idx;
  logic           sel_valid, sel_last;
  logic [DW-1:0]  sel_data;
  logic [SW-1:0]  sel_strb;
  logic           slot_free, accept, wd_hit;
  logic [CW-1:0]  cnt_inc;

  axis_rr_picker #(
    .C_NUM_SOURCES (C_NUM_SOURCES),
    .IW            (IW)
  ) u_picker (
    .req_i   (S_AXIS_TVALID),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < C_NUM_SOURCES; i++) begin
      if (grant_q == IW'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_data  = S_AXIS_TDATA[i*DW +: DW];
        sel_strb  = S_AXIS_TSTRB[i*SW +: SW];
        sel_last  = S_AXIS_TLAST[i];
      end
    end
  end

  // The slot can take a beat when empty or when its beat leaves this cycle.
  assign slot_free = !m_valid_q || M_AXIS_TREADY;
  assign accept    = (state_q == STREAM) && sel_valid && slot_free;
  assign cnt_inc   = cnt_q + CW'(1);
  assign wd_hit    = (cnt_inc == CW'(C_MAX_PKT_WORDS));

  always_comb begin
    S_AXIS_TREADY = '0;
    if (state_q == STREAM) begin
      for (int unsigned i = 0; i < C_NUM_SOURCES; i++) begin
        if (grant_q == IW'(i)) S_AXIS_TREADY[i] = slot_free;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    m_last_d  = m_last_q;
    ovr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (sel_last || wd_hit) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_strb_d  = sel_strb;
      m_last_d  = sel_last || wd_hit;
      ovr_d     = wd_hit && !sel_last;
    end else if (M_AXIS_TREADY) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_last_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_strb_q  <= m_strb_d;
      m_last_q  <= m_last_d;
      ovr_q     <= ovr_d;
    end
  end

  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TSTRB  = m_strb_q;
  assign M_AXIS_TLAST  = m_last_q;
  assign GRANT_ID      = grant_q;
  assign PKT_OVERRUN   = ovr_q;

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular N-to-1 AXI4-Stream arbiter sharing one master stream port between several stream generators, such as instances of the team's AXI-Stream counter master. Grant rotates round-robin and is held from the first beat to TLAST, so packets are never interleaved. Output is a registered slice with a beat-length watchdog that force-terminates runaway packets.

## Interface
- C_AXIS_TDATA_WIDTH, 32: data width in bits, multiple of 8.
- C_NUM_SOURCES, 4: number of requesting slave streams, 2..8.
- C_MAX_PKT_WORDS, 8: watchdog limit on beats per packet, ≥1.
- M_AXIS_ACLK  in  1  single clock for all logic.
- M_AXIS_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXIS_TVALID  in  C_NUM_SOURCES  per-source valid.
- S_AXIS_TDATA  in  C_NUM_SOURCES*C_AXIS_TDATA_WIDTH  packed data; source i at slice i.
- S_AXIS_TSTRB  in  C_NUM_SOURCES*C_AXIS_TDATA_WIDTH/8  packed strobes.
- S_AXIS_TLAST  in  C_NUM_SOURCES  per-source last.
- S_AXIS_TREADY  out  C_NUM_SOURCES  per-source ready; at most one bit set.
- M_AXIS_TVALID  out  1  output valid (registered).
- M_AXIS_TDATA  out  C_AXIS_TDATA_WIDTH  output data (registered).
- M_AXIS_TSTRB  out  C_AXIS_TDATA_WIDTH/8  output strobes (registered).
- M_AXIS_TLAST  out  1  output last (registered).
- M_AXIS_TREADY  in  1  downstream ready.
- GRANT_ID  out  clog2(C_NUM_SOURCES)  index of the current or last granted source.
- PKT_OVERRUN  out  1  one-cycle pulse on watchdog termination.

## Operation
- States: IDLE, STREAM.
- IDLE: all S_AXIS_TREADY are 0. If any S_AXIS_TVALID is set, pick the first set bit searching upward from last_grant+1 with wrap-around. Register it into GRANT_ID and go to STREAM. The beat counter clears to 0.
- STREAM: S_AXIS_TREADY[GRANT_ID] = !M_AXIS_TVALID || M_AXIS_TREADY. All other ready bits are 0.
- A beat is accepted when both valid and ready are set for the granted source. On acceptance, the output register loads that source's TDATA/TSTRB/TLAST, sets M_AXIS_TVALID, and the beat counter increments.
- Accepted beat with TLAST=1: last_grant <= GRANT_ID; go to IDLE.
- Accepted beat number C_MAX_PKT_WORDS with TLAST=0: force M_AXIS_TLAST=1 on that beat, pulse PKT_OVERRUN, set last_grant, and go to IDLE. The source's later beats are arbitrated as a new packet.
- Output hold: when M_AXIS_TVALID=1 and M_AXIS_TREADY=0, all M_AXIS outputs hold stable.
- Output clear: if the register holds a beat that is consumed in a cycle where no new beat is accepted, M_AXIS_TVALID drops to 0 on the next edge.
- Beat counter width: clog2(C_MAX_PKT_WORDS+1). Compare with equality; the counter never wraps.
- Reset, including mid-packet: state=IDLE, last_grant=C_NUM_SOURCES-1 so source 0 wins first, GRANT_ID=0, counter=0. M_AXIS_TVALID/TLAST=0, M_AXIS_TDATA/TSTRB=0, PKT_OVERRUN=0, S_AXIS_TREADY=0. A partially sent packet is abandoned, with no TLAST emitted.

## Timing
- Arbitration latency: TVALID seen in IDLE → S_AXIS_TREADY asserted the next cycle.
- Data latency: accepted beat appears on M_AXIS one cycle later.
- Full throughput within a packet: one beat per cycle while M_AXIS_TREADY=1.
- Packet gap: one IDLE cycle between packets, i.e. a one-cycle bubble at the source side.
- Same-edge events: TLAST acceptance and output consumption on the same edge are both honoured. The new arbitration uses the updated last_grant.
- A requester that deasserts TVALID mid-packet keeps the grant. The arbiter waits indefinitely, with watchdog counting accepted beats only.
- PKT_OVERRUN is registered, coincident with the forced-TLAST beat on M_AXIS.

## Structure
- Package axis_arb_pkg: state enum (IDLE, STREAM), a function for index width, and the reset constant for last_grant.
- Sub-module axis_rr_picker: combinational round-robin priority pick. Inputs are the request vector and last_grant; outputs are a valid flag and the index. Parameterised on C_NUM_SOURCES.
- Top module holds the FSM, beat counter, source mux, and output register slice.

## Test plan
- Single source: source 0 sends 3 beats 0x11,0x22,0x33 with TLAST on the third, M_AXIS_TREADY=1 → M_AXIS carries the same 3 beats with TLAST on 0x33; GRANT_ID=0; PKT_OVERRUN never set.
- Round-robin: all 4 sources continuously valid with 2-beat packets → grant order 0,1,2,3,0; no interleaving; one-cycle gap between packets.
- Backpressure: M_AXIS_TREADY toggles 1,0,0,1 during a packet → output holds stable while stalled; no beat lost or duplicated; S_AXIS_TREADY follows !M_AXIS_TVALID||M_AXIS_TREADY.
- Watchdog: source 2 sends 10 beats without TLAST, C_MAX_PKT_WORDS=8 → beat 8 carries TLAST=1 with a single PKT_OVERRUN pulse; beats 9–10 form a new packet after re-arbitration.
- Reset mid-packet: deassert M_AXIS_ARESETN after beat 2 of 5 → all outputs go to reset values immediately, without waiting for a clock edge; after release, source 0 gets priority.
- Same-edge: TLAST accepted while the output beat is consumed and source 1 is waiting → source 1 granted on the next-cycle arbitration with no extra bubble.
